// File: rtl/fifo_dual_mode.sv
// rtl/fifo_dual_mode.sv - single-clock FIFO with compile-time standard or first-word-fall-through read mode
module fifo_dual_mode #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter bit DATA_FLOAT_OUT = 1'b0
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          WR_EN,
    input  logic [DATA_WIDTH-1:0]         WR_DATA,
    output logic                          WR_FULL,
    output logic [$clog2(FIFO_DEPTH):0]   WR_CNT,
    input  logic                          RD_EN,
    output logic [DATA_WIDTH-1:0]         RD_DATA,
    output logic                          RD_EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   RD_CNT
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH:0]    count;
    logic [PTR_WIDTH:0]    count_nxt;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the registered count, so full-and-both admits only
    // the read and empty-and-both admits only the write without extra cases.
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign wr_acc = WR_EN & ~full;
    assign rd_acc = RD_EN & ~empty;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
        end
    end

    // Storage array carries no reset; stale contents are masked by the pointers.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    generate
        if (DATA_FLOAT_OUT) begin : g_fwft
            assign RD_DATA = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    rd_data_q <= '0;
                end else if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end

            assign RD_DATA = rd_data_q;
        end
    endgenerate

    assign WR_FULL  = full;
    assign RD_EMPTY = empty;
    assign WR_CNT   = count;
    assign RD_CNT   = count;

endmodule

// File: tb/tb_fifo_dual_mode.sv
// tb/tb_fifo_dual_mode.sv - directed self-checking bench driving a standard and an FWFT instance in lockstep
module tb_fifo_dual_mode;

    logic       CLK;
    logic       RST_N;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       RD_EN;

    logic       s_full, s_empty, f_full, f_empty;
    logic [4:0] s_wcnt, s_rcnt, f_wcnt, f_rcnt;
    logic [7:0] s_rdata, f_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic [7:0] exp_rd;
    logic       exp_valid;
    logic [7:0] pat [4];

    fifo_dual_mode #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DATA_FLOAT_OUT(1'b0)) u_std (
        .CLK(CLK), .RST_N(RST_N),
        .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_FULL(s_full), .WR_CNT(s_wcnt),
        .RD_EN(RD_EN), .RD_DATA(s_rdata), .RD_EMPTY(s_empty), .RD_CNT(s_rcnt)
    );

    fifo_dual_mode #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DATA_FLOAT_OUT(1'b1)) u_fwft (
        .CLK(CLK), .RST_N(RST_N),
        .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_FULL(f_full), .WR_CNT(f_wcnt),
        .RD_EN(RD_EN), .RD_DATA(f_rdata), .RD_EMPTY(f_empty), .RD_CNT(f_rcnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N   = 1'b0;
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        WR_DATA = 8'h00;
        pat[0] = 8'hAA; pat[1] = 8'h55; pat[2] = 8'hCC; pat[3] = 8'h33;

        // reset state
        tick();
        tick();
        check("rst_cnt",     {s_wcnt, s_rcnt, f_wcnt}, 32'h0);
        check("rst_empty",   {s_empty, f_empty}, 32'h3);
        check("rst_full",    {s_full, f_full}, 32'h0);
        check("rst_rdata_s", s_rdata, 32'h0);
        check("rst_rdata_f", f_rdata, 32'h0);
        RST_N = 1'b1;
        tick();

        // basic four-word standard round trip
        for (int i = 0; i < 4; i++) begin
            WR_EN = 1'b1; WR_DATA = pat[i];
            tick();
        end
        WR_EN = 1'b0;
        check("basic_wcnt4", s_wcnt, 32'd4);
        check("basic_rcnt4", s_rcnt, 32'd4);
        check("basic_empty0", s_empty, 32'd0);
        check("basic_fwft_head", f_rdata, 32'hAA);
        for (int i = 0; i < 4; i++) begin
            RD_EN = 1'b1;
            tick();
            check("basic_rd", s_rdata, 32'(pat[i]));
        end
        check("basic_cnt0", s_wcnt, 32'd0);
        check("basic_empty1", s_empty, 32'd1);
        tick();
        check("empty_read_hold", s_rdata, 32'h33);
        check("empty_read_cnt", s_rcnt, 32'd0);
        RD_EN = 1'b0;

        // fill to full, overflow write dropped
        for (int i = 0; i < 16; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'(i);
            tick();
        end
        check("fill_full", s_full, 32'd1);
        check("fill_cnt16", s_wcnt, 32'd16);
        WR_DATA = 8'hFF;
        tick();
        WR_EN = 1'b0;
        check("ovf_cnt16", s_wcnt, 32'd16);
        check("ovf_full", s_full, 32'd1);
        for (int i = 0; i < 16; i++) begin
            RD_EN = 1'b1;
            tick();
            check("fill_rd", s_rdata, 32'(i));
            if (i == 0) check("full_fall", s_full, 32'd0);
        end
        RD_EN = 1'b0;
        check("fill_empty", s_empty, 32'd1);

        // first-word-fall-through sequence
        WR_EN = 1'b1; WR_DATA = 8'hF0;
        tick();
        WR_EN = 1'b0;
        check("fwft_first", f_rdata, 32'hF0);
        check("fwft_nempty", f_empty, 32'd0);
        WR_EN = 1'b1; WR_DATA = 8'h0F;
        tick();
        WR_EN = 1'b0;
        check("fwft_hold", f_rdata, 32'hF0);
        RD_EN = 1'b1;
        tick();
        check("fwft_pop1", f_rdata, 32'h0F);
        tick();
        RD_EN = 1'b0;
        check("fwft_empty", f_empty, 32'd1);
        check("fwft_zero", f_rdata, 32'h0);

        // 20 streaming words across pointer wrap, scoreboarded
        q.delete();
        begin
            int w;
            w = 0;
            for (int c = 0; c < 23; c++) begin
                WR_EN   = (w < 20);
                WR_DATA = 8'h80 + 8'(w);
                RD_EN   = (c >= 3);
                exp_valid = 1'b0;
                if (RD_EN && q.size() > 0) begin
                    exp_rd = q.pop_front();
                    exp_valid = 1'b1;
                end
                if (WR_EN) begin
                    q.push_back(WR_DATA);
                    w++;
                end
                tick();
                if (exp_valid) check("stream_rd", s_rdata, 32'(exp_rd));
                check("stream_cnt_eq", s_rcnt, 32'(s_wcnt));
            end
        end
        WR_EN = 1'b0; RD_EN = 1'b0;
        check("stream_end_cnt", s_wcnt, 32'd0);
        check("stream_last", s_rdata, 32'h93);

        // simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'h10 + 8'(i);
            tick();
        end
        check("sim5_pre", s_wcnt, 32'd5);
        WR_DATA = 8'h15; RD_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
        check("sim5_cnt", s_wcnt, 32'd5);
        check("sim5_rd", s_rdata, 32'h10);
        for (int i = 1; i < 6; i++) begin
            tick();
            check("sim5_drain", s_rdata, 32'h10 + 32'(i));
        end
        RD_EN = 1'b0;

        // simultaneous at full
        for (int i = 0; i < 16; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'h20 + 8'(i);
            tick();
        end
        check("simfull_pre", s_full, 32'd1);
        WR_DATA = 8'h99; RD_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
        check("simfull_cnt15", s_wcnt, 32'd15);
        check("simfull_nfull", s_full, 32'd0);
        check("simfull_rd", s_rdata, 32'h20);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("simfull_drain", s_rdata, 32'h20 + 32'(i));
        end
        RD_EN = 1'b0;
        check("simfull_empty", s_empty, 32'd1);

        // simultaneous at empty
        WR_EN = 1'b1; RD_EN = 1'b1; WR_DATA = 8'h77;
        tick();
        WR_EN = 1'b0; RD_EN = 1'b0;
        check("simempty_cnt1", s_wcnt, 32'd1);
        check("simempty_hold", s_rdata, 32'h2F);
        check("simempty_fwft", f_rdata, 32'h77);
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        check("simempty_rd", s_rdata, 32'h77);

        // asynchronous reset with contents stored
        for (int i = 0; i < 7; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'h40 + 8'(i);
            tick();
        end
        WR_EN = 1'b0;
        check("arst_pre_cnt", s_wcnt, 32'd7);
        RST_N = 1'b0;
        #2;
        check("arst_cnt", {s_wcnt, s_rcnt, f_wcnt, f_rcnt}, 32'h0);
        check("arst_empty", {s_empty, f_empty}, 32'h3);
        check("arst_rdata", {s_rdata, f_rdata}, 32'h0);
        #1;
        RST_N = 1'b1;
        tick();
        WR_EN = 1'b1; WR_DATA = 8'h5A;
        tick();
        WR_EN = 1'b0;
        check("post_fwft", f_rdata, 32'h5A);
        check("post_cnt", s_wcnt, 32'd1);
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        check("post_rd", s_rdata, 32'h5A);
        check("post_empty", s_empty, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
